// File: rtl/decodificador_cuadratura.sv
// decodificador_cuadratura: quadrature encoder decoder with a glitch filter and a wrapping position counter.
//   clock       : rising-edge clock, sole domain
//   reset       : asynchronous, active-low reset
//   canal_a/b   : encoder channels, asynchronous to clock
//   habilitar   : enables position counting (decoding always runs)
//   cargar      : synchronous load of posicion from valor_carga
//   valor_carga : value loaded into posicion
//   paso        : one-cycle pulse per valid quadrature step
//   sentido     : direction of the last valid step (1 = up)
//   error_fase  : one-cycle pulse when A and B change together
//   posicion    : current position, 0..MODULO-1
//   fin_vuelta  : one-cycle pulse when posicion wraps
module decodificador_cuadratura #(
    parameter int MODULO = 16,
    parameter int FILTRO = 3,
    localparam int W = clogb2(MODULO - 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         canal_a,
    input  logic         canal_b,
    input  logic         habilitar,
    input  logic         cargar,
    input  logic [W-1:0] valor_carga,
    output logic         paso,
    output logic         sentido,
    output logic         error_fase,
    output logic [W-1:0] posicion,
    output logic         fin_vuelta
);
    function automatic int clogb2(input int valor);
        int r;
        r = 0;
        for (int v = valor; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    localparam int CW = clogb2(FILTRO);
    localparam logic [W-1:0] MAX = W'(MODULO - 1);

    typedef enum logic {SIN_INICIO, ACTIVO} estado_t;

    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    acept_q, acept_d;
    logic          valido_q, valido_d;
    logic          nuevo_q, nuevo_d;
    estado_t       estado_q, estado_d;
    logic [1:0]    prev_q, prev_d;
    logic          paso_q, paso_d;
    logic          sentido_q, sentido_d;
    logic          error_q, error_d;
    logic [W-1:0]  pos_q, pos_d;
    logic          fin_q, fin_d;

    logic          distinto, acepta, evaluar, sube, baja, salto;
    logic [CW-1:0] cuenta_sig;
    logic [1:0]    idx_n, idx_p, delta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            acept_q   <= '0;
            valido_q  <= 1'b0;
            nuevo_q   <= 1'b0;
            estado_q  <= SIN_INICIO;
            prev_q    <= '0;
            paso_q    <= 1'b0;
            sentido_q <= 1'b0;
            error_q   <= 1'b0;
            pos_q     <= '0;
            fin_q     <= 1'b0;
        end else begin
            sync1_q   <= {canal_a, canal_b};
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            acept_q   <= acept_d;
            valido_q  <= valido_d;
            nuevo_q   <= nuevo_d;
            estado_q  <= estado_d;
            prev_q    <= prev_d;
            paso_q    <= paso_d;
            sentido_q <= sentido_d;
            error_q   <= error_d;
            pos_q     <= pos_d;
            fin_q     <= fin_d;
        end
    end

    always_comb begin
        // Before the first acceptance every stable value counts as new, so it can initialise the decoder.
        distinto   = !valido_q || (sync2_q != acept_q);
        // cnt_q is 0 whenever no candidate is pending, so a stale cand_q match still starts at 1.
        cuenta_sig = ((sync2_q == cand_q) ? cnt_q : '0) + CW'(1);
        acepta     = distinto && (cuenta_sig == CW'(FILTRO));
        cand_d     = sync2_q;
        cnt_d      = (distinto && !acepta) ? cuenta_sig : '0;
        acept_d    = acepta ? sync2_q : acept_q;
        valido_d   = valido_q | acepta;
        nuevo_d    = acepta;
        // Map the Gray sequence 00,01,11,10 to 0..3 so a step is a +/-1 difference mod 4.
        idx_n      = {acept_q[1], ^acept_q};
        idx_p      = {prev_q[1], ^prev_q};
        delta      = idx_n - idx_p;
        evaluar    = nuevo_q && (estado_q == ACTIVO);
        sube       = evaluar && (delta == 2'd1);
        baja       = evaluar && (delta == 2'd3);
        salto      = evaluar && (delta == 2'd2);
        estado_d   = nuevo_q ? ACTIVO : estado_q;
        prev_d     = nuevo_q ? acept_q : prev_q;
        paso_d     = sube | baja;
        sentido_d  = sube ? 1'b1 : baja ? 1'b0 : sentido_q;
        error_d    = salto;
        pos_d      = cargar ? valor_carga :
                     !habilitar ? pos_q :
                     sube ? ((pos_q == MAX) ? '0 : pos_q + W'(1)) :
                     baja ? ((pos_q == '0) ? MAX : pos_q - W'(1)) : pos_q;
        fin_d      = habilitar && !cargar && ((sube && pos_q == MAX) || (baja && pos_q == '0));
    end

    assign paso       = paso_q;
    assign sentido    = sentido_q;
    assign error_fase = error_q;
    assign posicion   = pos_q;
    assign fin_vuelta = fin_q;
endmodule

// File: tb/tb_decodificador_cuadratura.sv
// tb_decodificador_cuadratura: directed scenario bench for decodificador_cuadratura (MODULO=16, FILTRO=3).
module tb_decodificador_cuadratura;
    logic       clock, reset, canal_a, canal_b, habilitar, cargar;
    logic [3:0] valor_carga;
    logic       paso, sentido, error_fase, fin_vuelta;
    logic [3:0] posicion;
    int checks, failures;

    decodificador_cuadratura #(.MODULO(16), .FILTRO(3)) dut (
        .clock(clock), .reset(reset), .canal_a(canal_a), .canal_b(canal_b),
        .habilitar(habilitar), .cargar(cargar), .valor_carga(valor_carga),
        .paso(paso), .sentido(sentido), .error_fase(error_fase),
        .posicion(posicion), .fin_vuelta(fin_vuelta)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Runs n cycles, sampling 1 time unit after each rising edge; lat is the edge index of the first paso/error_fase.
    task automatic correr(input int n, output int np, output int ne, output int nf, output int lat, output logic [3:0] pos_p);
        np = 0; ne = 0; nf = 0; lat = 0; pos_p = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clock); #1;
            if (paso) begin np++; if (lat == 0) lat = i; pos_p = posicion; end
            if (error_fase) begin ne++; if (lat == 0) lat = i; end
            if (fin_vuelta) nf++;
        end
    endtask

    task automatic test_reset();
        int np, ne, nf, lat;
        logic [3:0] pp;
        #1 reset = 0;
        #1;
        checks++; if (paso !== 1'b0) begin failures++; $display("FAIL rst_paso got=%b exp=0", paso); end
        checks++; if (sentido !== 1'b0) begin failures++; $display("FAIL rst_sentido got=%b exp=0", sentido); end
        checks++; if (error_fase !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error_fase); end
        checks++; if (posicion !== 4'd0) begin failures++; $display("FAIL rst_pos got=%0d exp=0", posicion); end
        checks++; if (fin_vuelta !== 1'b0) begin failures++; $display("FAIL rst_fin got=%b exp=0", fin_vuelta); end
        #20 @(negedge clock) reset = 1;
        correr(10, np, ne, nf, lat, pp);
        checks++; if (np + ne !== 0) begin failures++; $display("FAIL init_silent got=%0d exp=0", np + ne); end
    endtask

    task automatic test_up();
        int np, ne, nf, lat;
        logic [3:0] pp;
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int s = 0; s < 4; s++) begin
            {canal_a, canal_b} = seq[s];
            correr(10, np, ne, nf, lat, pp);
            checks++; if (np !== 1 || ne !== 0) begin failures++; $display("FAIL up%0d_pulses got=%0d/%0d exp=1/0", s, np, ne); end
            checks++; if (lat !== 6) begin failures++; $display("FAIL up%0d_latency got=%0d exp=6", s, lat); end
            checks++; if (pp !== 4'(s + 1)) begin failures++; $display("FAIL up%0d_pos got=%0d exp=%0d", s, pp, s + 1); end
            checks++; if (sentido !== 1'b1) begin failures++; $display("FAIL up%0d_sentido got=%b exp=1", s, sentido); end
        end
    endtask

    task automatic test_wrap();
        int np, ne, nf, lat;
        logic [3:0] pp;
        cargar = 1; valor_carga = 4'd15;
        @(posedge clock); #1;
        cargar = 0;
        checks++; if (posicion !== 4'd15) begin failures++; $display("FAIL load15 got=%0d exp=15", posicion); end
        {canal_a, canal_b} = 2'b01;
        correr(10, np, ne, nf, lat, pp);
        checks++; if (np !== 1 || nf !== 1 || pp !== 4'd0) begin failures++; $display("FAIL wrap_up got=np%0d nf%0d pos%0d exp=np1 nf1 pos0", np, nf, pp); end
        {canal_a, canal_b} = 2'b00;
        correr(10, np, ne, nf, lat, pp);
        checks++; if (np !== 1 || nf !== 1 || pp !== 4'd15) begin failures++; $display("FAIL wrap_down got=np%0d nf%0d pos%0d exp=np1 nf1 pos15", np, nf, pp); end
        checks++; if (sentido !== 1'b0) begin failures++; $display("FAIL wrap_sentido got=%b exp=0", sentido); end
    endtask

    task automatic test_glitch();
        int np, ne, nf, lat;
        logic [3:0] pp;
        canal_a = 1;
        @(posedge clock); @(posedge clock); #1;
        canal_a = 0;
        correr(12, np, ne, nf, lat, pp);
        checks++; if (np + ne !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", np + ne); end
        checks++; if (posicion !== 4'd15) begin failures++; $display("FAIL glitch_pos got=%0d exp=15", posicion); end
    endtask

    task automatic test_error();
        int np, ne, nf, lat;
        logic [3:0] pp;
        {canal_a, canal_b} = 2'b11;
        correr(10, np, ne, nf, lat, pp);
        checks++; if (ne !== 1 || np !== 0) begin failures++; $display("FAIL err_pulses got=%0d/%0d exp=1/0", ne, np); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL err_latency got=%0d exp=6", lat); end
        checks++; if (posicion !== 4'd15 || sentido !== 1'b0) begin failures++; $display("FAIL err_hold got=pos%0d s%b exp=pos15 s0", posicion, sentido); end
        {canal_a, canal_b} = 2'b10;
        correr(10, np, ne, nf, lat, pp);
        checks++; if (np !== 1 || pp !== 4'd0 || sentido !== 1'b1) begin failures++; $display("FAIL err_next_up got=np%0d pos%0d s%b exp=np1 pos0 s1", np, pp, sentido); end
    endtask

    task automatic test_load_hold();
        int np, ne, nf, lat, tot;
        logic [3:0] pp;
        logic [1:0] seq [3] = '{2'b01, 2'b11, 2'b10};
        np = 0; nf = 0; lat = 0;
        {canal_a, canal_b} = 2'b00;
        valor_carga = 4'd9;
        for (int i = 1; i <= 10; i++) begin
            cargar = (i == 6);
            @(posedge clock); #1;
            if (paso) begin np++; lat = i; end
            if (fin_vuelta) nf++;
        end
        cargar = 0;
        checks++; if (np !== 1 || lat !== 6) begin failures++; $display("FAIL load_step got=np%0d at%0d exp=np1 at6", np, lat); end
        checks++; if (posicion !== 4'd9 || nf !== 0) begin failures++; $display("FAIL load_pos got=pos%0d nf%0d exp=pos9 nf0", posicion, nf); end
        habilitar = 0;
        tot = 0;
        for (int s = 0; s < 3; s++) begin
            {canal_a, canal_b} = seq[s];
            correr(10, np, ne, nf, lat, pp);
            tot += np;
            checks++; if (posicion !== 4'd9 || nf !== 0) begin failures++; $display("FAIL hold%0d got=pos%0d nf%0d exp=pos9 nf0", s, posicion, nf); end
        end
        checks++; if (tot !== 3) begin failures++; $display("FAIL hold_pasos got=%0d exp=3", tot); end
        habilitar = 1;
    endtask

    task automatic test_reset_mid();
        int np, ne, nf, lat;
        logic [3:0] pp;
        {canal_a, canal_b} = 2'b11;
        correr(3, np, ne, nf, lat, pp);
        #2 reset = 0;
        #1;
        checks++; if ({paso, sentido, error_fase, fin_vuelta} !== 4'b0 || posicion !== 4'd0) begin
            failures++; $display("FAIL async_reset got=p%b s%b e%b f%b pos%0d exp=all0", paso, sentido, error_fase, fin_vuelta, posicion);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1;
        correr(15, np, ne, nf, lat, pp);
        checks++; if (np + ne !== 0 || posicion !== 4'd0) begin failures++; $display("FAIL rel11 got=pulses%0d pos%0d exp=0 0", np + ne, posicion); end
        {canal_a, canal_b} = 2'b10;
        correr(10, np, ne, nf, lat, pp);
        checks++; if (np !== 1 || lat !== 6 || pp !== 4'd1) begin failures++; $display("FAIL rel_step got=np%0d at%0d pos%0d exp=1 6 1", np, lat, pp); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1; canal_a = 0; canal_b = 0; habilitar = 1; cargar = 0; valor_carga = '0;
        test_reset();
        test_up();
        test_wrap();
        test_glitch();
        test_error();
        test_load_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
